// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU encodings. ALUControl operation codes and the
//                ALUOp instruction-class encodings, used by the control
//                stage and by the ALU itself.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes driven on ALUControl
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_ctrl_e;

  // Instruction classes carried on ALUOp
  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  // funct3 / funct7 values recognised by the decoder
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode
//  Description : Purely combinational ALU control decode. Maps the
//                instruction class plus funct3/funct7 to an ALU operation
//                code and selects the operands. Undecodable combinations
//                produce an ADD of zero operands flagged as illegal.
//  Ports       : alu_op/funct3/funct7  - instruction fields
//                rs1_val/rs2_val/imm   - candidate operands
//                op1/op2/alu_control   - decoded ALU request
//                illegal               - combination was not decodable
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [3:0]        alu_control,
  output logic              illegal
);

  logic       legal;
  logic       use_imm;
  logic [3:0] code;

  always_comb begin
    legal   = 1'b1;
    use_imm = 1'b0;
    code    = ALU_ADD;
    case (alu_op)
      ALUOP_LDST: begin
        code    = ALU_ADD;
        use_imm = 1'b1;
      end
      ALUOP_BRANCH: begin
        code = ALU_SUB;
      end
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  code = ALU_ADD;
            F3_AND:  code = ALU_AND;
            F3_OR:   code = ALU_OR;
            F3_SLT:  code = ALU_SLT;
            default: legal = 1'b0;
          endcase
        end else if (funct3 == F3_ADD && funct7 == F7_ALT) begin
          code = ALU_SUB;
        end else if (funct3 == F3_ADD && funct7 == F7_MULDIV) begin
          code = ALU_MUL;
        end else begin
          legal = 1'b0;
        end
      end
      default: begin  // I-type: funct7 carries immediate bits, so ignore it
        use_imm = 1'b1;
        case (funct3)
          F3_ADD:  code = ALU_ADD;
          F3_AND:  code = ALU_AND;
          F3_OR:   code = ALU_OR;
          F3_SLT:  code = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
    endcase
  end

  // Illegal ops are issued as a harmless ADD of zeros
  assign op1         = legal ? rs1_val : '0;
  assign op2         = legal ? (use_imm ? imm : rs2_val) : '0;
  assign alu_control = legal ? code : ALU_ADD;
  assign illegal     = ~legal;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_stage
//  Description : ALU control pipeline stage. Decodes each request, then
//                buffers it in a main register backed by a one-entry skid
//                register so that inReady is purely registered. Counts
//                retired illegal ops with a saturating counter.
//  Ports       : clk, rst_n                     - clock, async active-low reset
//                inValid/inReady, ALUOp, funct3,
//                funct7, rs1Val, rs2Val, imm    - upstream request
//                flush                          - synchronous pipeline kill
//                outValid/outReady, op1, op2,
//                ALUControl, illegal            - issued ALU request
//                illegalCount                   - retired illegal-op count
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [DATA_W-1:0] rs1Val,
  input  logic [DATA_W-1:0] rs2Val,
  input  logic [DATA_W-1:0] imm,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [3:0]        ALUControl,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegalCount
);

  logic [DATA_W-1:0] dec_op1, dec_op2;
  logic [3:0]        dec_ctrl;
  logic              dec_ill;

  alu_decode #(.DATA_W(DATA_W)) u_decode (
    .alu_op      (ALUOp),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1_val     (rs1Val),
    .rs2_val     (rs2Val),
    .imm         (imm),
    .op1         (dec_op1),
    .op2         (dec_op2),
    .alu_control (dec_ctrl),
    .illegal     (dec_ill)
  );

  logic              main_valid, skid_valid, in_ready_q;
  logic [DATA_W-1:0] main_op1, main_op2, skid_op1, skid_op2;
  logic [3:0]        main_ctrl, skid_ctrl;
  logic              main_ill, skid_ill;
  logic [CNT_W-1:0]  ill_cnt;

  logic accept, retire, skid_next;

  assign accept = inValid && in_ready_q && !flush;
  assign retire = main_valid && outReady;

  // Skid occupancy after this edge; drives the registered inReady so that
  // outReady never reaches inReady combinationally.
  assign skid_next = skid_valid ? !retire : (accept && main_valid && !retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_op1   <= '0;
      main_op2   <= '0;
      main_ctrl  <= ALU_ADD;
      main_ill   <= 1'b0;
      skid_op1   <= '0;
      skid_op2   <= '0;
      skid_ctrl  <= ALU_ADD;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= !skid_next;
      if (retire) begin
        if (skid_valid) begin
          // inReady is low while skid is full, so no accept can coincide
          main_op1   <= skid_op1;
          main_op2   <= skid_op2;
          main_ctrl  <= skid_ctrl;
          main_ill   <= skid_ill;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_op1  <= dec_op1;
          main_op2  <= dec_op2;
          main_ctrl <= dec_ctrl;
          main_ill  <= dec_ill;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_op1   <= dec_op1;
          skid_op2   <= dec_op2;
          skid_ctrl  <= dec_ctrl;
          skid_ill   <= dec_ill;
          skid_valid <= 1'b1;
        end else begin
          main_op1   <= dec_op1;
          main_op2   <= dec_op2;
          main_ctrl  <= dec_ctrl;
          main_ill   <= dec_ill;
          main_valid <= 1'b1;
        end
      end
    end
  end

  // A flushed entry never retires, so the count is left alone on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (!flush && retire && main_ill && (ill_cnt != {CNT_W{1'b1}})) begin
      ill_cnt <= ill_cnt + CNT_W'(1);
    end
  end

  assign inReady      = in_ready_q;
  assign outValid     = main_valid;
  assign op1          = main_op1;
  assign op2          = main_op2;
  assign ALUControl   = main_ctrl;
  assign illegal      = main_ill;
  assign illegalCount = ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_stage
//  Description : Self-checking bench for alu_ctrl_stage. Directed decode
//                table, hand-written flow-control/flush/reset sequences and
//                random traffic compared against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] op1, op2;
  logic [3:0]  alu_ctrl;
  logic [7:0]  ill_count;

  alu_ctrl_stage #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(in_valid), .inReady(in_ready),
    .ALUOp(alu_op), .funct3(funct3), .funct7(funct7),
    .rs1Val(rs1), .rs2Val(rs2), .imm(imm), .flush(flush),
    .outValid(out_valid), .outReady(out_ready),
    .op1(op1), .op2(op2), .ALUControl(alu_ctrl),
    .illegal(illegal), .illegalCount(ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [1:0]  aop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, im;
    logic [3:0]  ctrl;
    logic        ill;
    logic [31:0] e1, e2;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  int   mcnt = 0;

  // Reference decode written directly from the instruction-class table
  function automatic exp_t ref_decode(logic [1:0] aop, logic [2:0] f3, logic [6:0] f7,
                                      logic [31:0] a, logic [31:0] b, logic [31:0] im);
    exp_t e;
    int   code;
    code = -1;
    if (aop == 2'd0) code = 2;
    else if (aop == 2'd1) code = 6;
    else if (aop == 2'd2) begin
      if      (f3 == 3'd0 && f7 == 7'd0)  code = 2;
      else if (f3 == 3'd0 && f7 == 7'h20) code = 6;
      else if (f3 == 3'd0 && f7 == 7'd1)  code = 8;
      else if (f3 == 3'd7 && f7 == 7'd0)  code = 0;
      else if (f3 == 3'd6 && f7 == 7'd0)  code = 1;
      else if (f3 == 3'd2 && f7 == 7'd0)  code = 7;
    end else begin
      if      (f3 == 3'd0) code = 2;
      else if (f3 == 3'd7) code = 0;
      else if (f3 == 3'd6) code = 1;
      else if (f3 == 3'd2) code = 7;
    end
    if (code < 0) begin
      e.op1 = 0; e.op2 = 0; e.ctrl = 4'd2; e.ill = 1'b1;
    end else begin
      e.op1  = a;
      e.op2  = (aop == 2'd0 || aop == 2'd3) ? im : b;
      e.ctrl = 4'(code);
      e.ill  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("outValid", 64'(out_valid), 64'(q.size() > 0));
    chk("inReady", 64'(in_ready), 64'(q.size() < 2));
    chk("illegalCount", 64'(ill_count), 64'(mcnt));
    if (q.size() > 0) begin
      chk("op1", 64'(op1), 64'(q[0].op1));
      chk("op2", 64'(op2), 64'(q[0].op2));
      chk("ALUControl", 64'(alu_ctrl), 64'(q[0].ctrl));
      chk("illegal", 64'(illegal), 64'(q[0].ill));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " outValid"}, 64'(out_valid), 64'd0);
    chk({tag, " inReady"}, 64'(in_ready), 64'd1);
    chk({tag, " op1"}, 64'(op1), 64'd0);
    chk({tag, " op2"}, 64'(op2), 64'd0);
    chk({tag, " ALUControl"}, 64'(alu_ctrl), 64'd2);
    chk({tag, " illegal"}, 64'(illegal), 64'd0);
    chk({tag, " illegalCount"}, 64'(ill_count), 64'd0);
  endtask

  // Called at a falling edge: drive, clock, update model, check at next fall
  task automatic cycle(input logic iv, input logic [1:0] aop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ordy, input logic fl);
    bit acc, ret;
    in_valid = iv; alu_op = aop; funct3 = f3; funct7 = f7;
    rs1 = a; rs2 = b; imm = im; out_ready = ordy; flush = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      ret = ordy && (q.size() > 0);
      if (ret) begin
        if (q[0].ill && mcnt < 255) mcnt++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_decode(aop, f3, f7, a, b, im));
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{2'b10, 3'b000, 7'h00, 32'd5,      32'd7,     32'd99,        4'b0010, 1'b0, 32'd5,      32'd7};
    vecs[1]  = '{2'b10, 3'b000, 7'h20, 32'd9,      32'd4,     32'd0,         4'b0110, 1'b0, 32'd9,      32'd4};
    vecs[2]  = '{2'b10, 3'b000, 7'h01, 32'd3,      32'd6,     32'd1,         4'b1000, 1'b0, 32'd3,      32'd6};
    vecs[3]  = '{2'b10, 3'b111, 7'h00, 32'hF0,     32'h3C,    32'd1,         4'b0000, 1'b0, 32'hF0,     32'h3C};
    vecs[4]  = '{2'b10, 3'b110, 7'h00, 32'h11,     32'h22,    32'd1,         4'b0001, 1'b0, 32'h11,     32'h22};
    vecs[5]  = '{2'b10, 3'b010, 7'h00, 32'h7,      32'h8,     32'd1,         4'b0111, 1'b0, 32'h7,      32'h8};
    vecs[6]  = '{2'b10, 3'b001, 7'h00, 32'h55,     32'h66,    32'h77,        4'b0010, 1'b1, 32'd0,      32'd0};
    vecs[7]  = '{2'b10, 3'b111, 7'h20, 32'h55,     32'h66,    32'h77,        4'b0010, 1'b1, 32'd0,      32'd0};
    vecs[8]  = '{2'b10, 3'b000, 7'h21, 32'h55,     32'h66,    32'h77,        4'b0010, 1'b1, 32'd0,      32'd0};
    vecs[9]  = '{2'b00, 3'b101, 7'h7F, 32'h100,    32'h200,   32'hFFFFFFFC,  4'b0010, 1'b0, 32'h100,    32'hFFFFFFFC};
    vecs[10] = '{2'b01, 3'b001, 7'h00, 32'd10,     32'd3,     32'd50,        4'b0110, 1'b0, 32'd10,     32'd3};
    vecs[11] = '{2'b11, 3'b111, 7'h20, 32'h1234,   32'h9,     32'hFF,        4'b0000, 1'b0, 32'h1234,   32'hFF};
    vecs[12] = '{2'b11, 3'b000, 7'h7F, 32'h40,     32'h9,     32'h10,        4'b0010, 1'b0, 32'h40,     32'h10};
    vecs[13] = '{2'b11, 3'b110, 7'h00, 32'h41,     32'h9,     32'h11,        4'b0001, 1'b0, 32'h41,     32'h11};
    vecs[14] = '{2'b11, 3'b010, 7'h01, 32'h42,     32'h9,     32'h12,        4'b0111, 1'b0, 32'h42,     32'h12};
    vecs[15] = '{2'b11, 3'b011, 7'h00, 32'h43,     32'h9,     32'h13,        4'b0010, 1'b1, 32'd0,      32'd0};

    // Reset state with the clock running
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle(1'b1);

    // Decode table, streamed back-to-back with outReady high
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, vecs[i].aop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].im, 1'b1, 1'b0);
      chk($sformatf("vec%0d outValid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d ALUControl", i), 64'(alu_ctrl), 64'(vecs[i].ctrl));
      chk($sformatf("vec%0d illegal", i), 64'(illegal), 64'(vecs[i].ill));
      chk($sformatf("vec%0d op1", i), 64'(op1), 64'(vecs[i].e1));
      chk($sformatf("vec%0d op2", i), 64'(op2), 64'(vecs[i].e2));
    end
    idle(1'b1);

    // Backpressure: three offers while stalled, two taken, issued in order
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hA1, 32'd1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hA2, 32'd2, 32'd0, 1'b0, 1'b0);
    chk("bp inReady after 2nd", 64'(in_ready), 64'd0);
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hA3, 32'd3, 32'd0, 1'b0, 1'b0);
    chk("bp held op1", 64'(op1), 64'hA1);
    chk("bp held outValid", 64'(out_valid), 64'd1);
    idle(1'b1);
    chk("bp 2nd issue op1", 64'(op1), 64'hA2);
    chk("bp 2nd issue outValid", 64'(out_valid), 64'd1);
    idle(1'b1);
    chk("bp drained", 64'(out_valid), 64'd0);

    // Saturating illegal counter
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 2'b10, 3'b001, 7'h00, 32'(i), 32'(i), 32'(i), 1'b1, 1'b0);
    idle(1'b1);
    chk("illegalCount saturated", 64'(ill_count), 64'd255);

    // Mid-stream asynchronous reset
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hC1, 32'd1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hC2, 32'd2, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    q.delete();
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("held reset");
    rst_n = 1'b1;
    idle(1'b1);
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hD1, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("post-reset first issue op1", 64'(op1), 64'hD1);
    idle(1'b1);

    // Flush with main (illegal) and skid full, new input and outReady high
    cycle(1'b1, 2'b10, 3'b001, 7'h00, 32'hB1, 32'd1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hB2, 32'd2, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 3'b000, 7'h00, 32'hB3, 32'd3, 32'd0, 1'b1, 1'b1);
    chk("flush outValid", 64'(out_valid), 64'd0);
    chk("flush inReady", 64'(in_ready), 64'd1);
    chk("flush illegalCount", 64'(ill_count), 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [6:0] f7r;
      case ($urandom_range(3))
        0: f7r = 7'h00;
        1: f7r = 7'h20;
        2: f7r = 7'h01;
        default: f7r = 7'($urandom);
      endcase
      cycle(1'($urandom_range(9) < 7), 2'($urandom), 3'($urandom), f7r,
            $urandom, $urandom, $urandom,
            1'($urandom_range(9) < 6), 1'($urandom_range(19) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter CNT_W, default 8, illegal-op counter width.
REQ-003 SHALL have port clk, input, 1, sole clock with all state on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have the following upstream ports:
- inValid, input, 1, decode request valid.
- inReady, output, 1, stage can accept.
- ALUOp, input, 2, instruction class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
- funct3, input, 3, instruction funct3.
- funct7, input, 7, instruction funct7.
- rs1Val, input, DATA_W, source operand 1.
- rs2Val, input, DATA_W, source operand 2.
- imm, input, DATA_W, sign-extended immediate.
- flush, input, 1, synchronous pipeline kill.
REQ-006 SHALL have the following downstream ports to the ALU:
- outValid, output, 1, issued operation valid.
- outReady, input, 1, ALU consumes.
- op1, output, DATA_W, ALU operand 1.
- op2, output, DATA_W, ALU operand 2.
- ALUControl, output, 4, ALU operation code.
- illegal, output, 1, issued entry had an undecodable op.
- illegalCount, output, CNT_W, saturating count of illegal ops issued.

Function
REQ-007 SHALL decode ALUOp 00 to ALUControl 0010 (add), with op2 = imm.
REQ-008 SHALL decode ALUOp 01 to ALUControl 0110 (sub), with op2 = rs2Val.
REQ-009 SHALL decode ALUOp 10 as follows, with op2 = rs2Val:
- funct3 000 with funct7 0000000 -> 0010.
- funct3 000 with funct7 0100000 -> 0110.
- funct3 000 with funct7 0000001 -> 1000.
- funct3 111 with funct7 0000000 -> 0000.
- funct3 110 with funct7 0000000 -> 0001.
- funct3 010 with funct7 0000000 -> 0111.
REQ-010 SHALL decode ALUOp 11 by funct3 (000 -> 0010, 111 -> 0000, 110 -> 0001, 010 -> 0111), with op2 = imm and funct7 ignored.
REQ-011 SHALL set op1 = rs1Val for every legal op.
REQ-012 SHALL treat any combination not listed in REQ-009 or REQ-010 as illegal, issuing ALUControl 0010, op1 = 0, op2 = 0, illegal = 1.
REQ-013 SHALL accept a request on a rising edge where inValid && inReady && !flush.
REQ-014 SHALL present an accepted request at the outputs with outValid = 1 on the edge after acceptance when the stage was empty (1-cycle latency).
REQ-015 SHALL hold outValid, op1, op2, ALUControl and illegal stable while outValid && !outReady.
REQ-016 SHALL retire the output entry on an edge where outValid && outReady.
REQ-017 SHALL contain a main register plus a one-entry skid register; inReady SHALL be a registered !skidValid (no combinational path from outReady to inReady).
REQ-018 SHALL park an accept made while the main register is stalled in the skid register; the skid entry SHALL move to main on the next retire, preserving order.
REQ-019 SHALL sustain one accept and one retire per cycle indefinitely when outReady = 1.
REQ-020 SHALL, on a simultaneous accept and retire with an empty skid, load the new entry directly into main.
REQ-021 SHALL, on flush, clear both valid bits at the next edge and discard any same-cycle input.
REQ-022 SHALL give flush priority over accept and retire.
REQ-023 SHALL have inReady = 1 on the cycle after a flush.
REQ-024 SHALL increment illegalCount on each retire of an entry with illegal = 1 and saturate at all-ones.
REQ-025 SHALL leave illegalCount unchanged on flush.

Reset
REQ-026 SHALL, while rst_n = 0, force the following regardless of clk:
- outValid = 0, inReady = 1.
- op1 = 0, op2 = 0.
- ALUControl = 0010, illegal = 0.
- illegalCount = 0.
- skid register empty.
REQ-027 SHALL discard in-flight entries on a mid-operation reset, with no outValid pulse on release.

Structure
REQ-028 SHALL define the six ALUControl codes and the ALUOp class encodings as named constants in a shared package alu_pkg, used by both this block and the ALU.
REQ-029 SHALL place decode (REQ-007..REQ-012) in a combinational sub-module alu_decode instantiated once ahead of the skid/main registers.

Verification
REQ-030 SHALL verify: ALUOp=10, funct3=000, funct7=0100000, rs1Val=9, rs2Val=4, outReady=1 -> next cycle outValid=1, ALUControl=0110, op1=9, op2=4.
REQ-031 SHALL verify: ALUOp=11, funct3=111, imm=0xFF, rs1Val=0x1234 -> ALUControl=0000, op2=0xFF.
REQ-032 SHALL verify: outReady=0 for 3 cycles while 3 requests are offered -> 2 accepted, inReady=0 after the second; on outReady=1 both issue in order with no loss or duplication.
REQ-033 SHALL verify: ALUOp=10, funct3=001 -> illegal=1, ALUControl=0010, op1=op2=0; after 300 such retires illegalCount=255.
REQ-034 SHALL verify: flush asserted with main and skid full plus inValid=1 -> next cycle outValid=0, inReady=1, and the flushed ops are never issued.
REQ-035 SHALL verify: rst_n pulsed low mid-stream -> outputs at reset values immediately, and the first post-reset issue is the first post-reset request.
